// File: rtl/c2h_pkg.sv
// Shared constants, helpers and state encoding for the C2H AXI-Stream serializer.
// Default geometry: a 4072-bit packet sent as eight 512-bit beats.
package c2h_pkg;

  localparam int unsigned PKT_W_DEF  = 4072;
  localparam int unsigned BEAT_W_DEF = 512;

  function automatic int unsigned nbeats(input int unsigned pkt_w, input int unsigned beat_w);
    return (pkt_w + beat_w - 1) / beat_w;
  endfunction

  // Valid bytes carried by the final beat of a packet.
  function automatic int unsigned last_bytes(input int unsigned pkt_w, input int unsigned beat_w);
    return pkt_w / 8 - (nbeats(pkt_w, beat_w) - 1) * (beat_w / 8);
  endfunction

  localparam int unsigned NBEATS_DEF = nbeats(PKT_W_DEF, BEAT_W_DEF);
  localparam int unsigned LAST_BYTES = last_bytes(PKT_W_DEF, BEAT_W_DEF);
  localparam logic [BEAT_W_DEF/8-1:0] LAST_KEEP =
    {(BEAT_W_DEF/8){1'b1}} >> (BEAT_W_DEF/8 - LAST_BYTES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/c2h_axis_serializer.sv
// Latches one packet from the packer and streams it LSB-first as AXI-Stream beats to XDMA C2H,
// then pulses in_next so the packer can advance. Counts completed packets, flags dropped ones.
module c2h_axis_serializer
  import c2h_pkg::*;
#(
  parameter int unsigned PKT_W  = PKT_W_DEF,
  parameter int unsigned BEAT_W = BEAT_W_DEF,
  parameter int unsigned CNT_W  = 32
) (
  input  logic                m_axis_c2h_aclk,
  input  logic                m_axis_c2h_areset,
  input  logic                flush,
  input  logic [PKT_W-1:0]    in_data,
  input  logic                in_valid,
  output logic                in_next,
  output logic [BEAT_W-1:0]   m_axis_c2h_tdata,
  output logic [BEAT_W/8-1:0] m_axis_c2h_tkeep,
  output logic                m_axis_c2h_tvalid,
  input  logic                m_axis_c2h_tready,
  output logic                m_axis_c2h_tlast,
  output logic                busy,
  output logic [CNT_W-1:0]    pkt_count,
  output logic                drop_err
);

  localparam int unsigned NBEATS  = nbeats(PKT_W, BEAT_W);
  localparam int unsigned KEEP_W  = BEAT_W / 8;
  localparam int unsigned SHREG_W = NBEATS * BEAT_W;
  localparam int unsigned BC_W    = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [KEEP_W-1:0] KEEP_LAST = {KEEP_W{1'b1}} >> (KEEP_W - last_bytes(PKT_W, BEAT_W));
  localparam logic [BC_W-1:0]   LAST_BEAT = BC_W'(NBEATS - 1);

  state_t             state;
  logic [SHREG_W-1:0] shreg;
  logic [BC_W-1:0]    beat_cnt;
  logic               flush_pend;
  logic               is_last;

  assign is_last          = (beat_cnt == LAST_BEAT);
  assign m_axis_c2h_tdata = shreg[BEAT_W-1:0];

  // NOTE: every output of an always_comb gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    m_axis_c2h_tkeep = '0;
    m_axis_c2h_tlast = 1'b0;
    if (m_axis_c2h_tvalid) begin
      m_axis_c2h_tkeep = is_last ? KEEP_LAST : {KEEP_W{1'b1}};
      m_axis_c2h_tlast = is_last;
    end
  end

  // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge m_axis_c2h_aclk) begin
    if (m_axis_c2h_areset) begin
      state             <= IDLE;
      // NOTE: the shift register is cleared on reset on purpose so tdata reads as zero while idle.
      shreg             <= '0;
      beat_cnt          <= '0;
      m_axis_c2h_tvalid <= 1'b0;
      in_next           <= 1'b0;
      busy              <= 1'b0;
      flush_pend        <= 1'b0;
      pkt_count         <= '0;
      drop_err          <= 1'b0;
    end else begin
      in_next <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid && !flush) begin
            shreg             <= SHREG_W'(in_data);
            beat_cnt          <= '0;
            flush_pend        <= 1'b0;
            m_axis_c2h_tvalid <= 1'b1;
            busy              <= 1'b1;
            state             <= SEND;
          end
        end
        SEND: begin
          if (in_valid) drop_err <= 1'b1;
          if (flush) flush_pend <= 1'b1;
          if (m_axis_c2h_tvalid && m_axis_c2h_tready) begin
            shreg    <= shreg >> BEAT_W;
            beat_cnt <= beat_cnt + BC_W'(1);
            if (is_last) begin
              m_axis_c2h_tvalid <= 1'b0;
              state             <= DONE;
              // A flushed transfer still drains, but is neither counted nor acknowledged.
              if (!(flush_pend || flush)) begin
                in_next   <= 1'b1;
                pkt_count <= pkt_count + CNT_W'(1);
              end
            end
          end
        end
        DONE: begin
          if (in_valid) drop_err <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (flush) begin
        pkt_count <= '0;
        drop_err  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_c2h_axis_serializer.sv
// Scoreboard bench for c2h_axis_serializer: stimulus pushes expected beats, a monitor pops and
// compares on every AXIS handshake and checks that stalled beats hold steady.
module tb_c2h_axis_serializer;

  localparam int PKT_W  = 4072;
  localparam int BEAT_W = 512;
  localparam int CNT_W  = 32;
  localparam int KW     = BEAT_W / 8;
  localparam int NB     = (PKT_W + BEAT_W - 1) / BEAT_W;

  typedef struct {
    logic [BEAT_W-1:0] data;
    logic [KW-1:0]     keep;
    logic              last;
  } beat_t;

  logic              clk = 1'b0;
  logic              areset;
  logic              flush;
  logic [PKT_W-1:0]  in_data;
  logic              in_valid;
  logic              in_next;
  logic [BEAT_W-1:0] tdata;
  logic [KW-1:0]     tkeep;
  logic              tvalid;
  logic              tready;
  logic              tlast;
  logic              busy;
  logic [CNT_W-1:0]  pkt_count;
  logic              drop_err;

  c2h_axis_serializer dut (
    .m_axis_c2h_aclk   (clk),
    .m_axis_c2h_areset (areset),
    .flush             (flush),
    .in_data           (in_data),
    .in_valid          (in_valid),
    .in_next           (in_next),
    .m_axis_c2h_tdata  (tdata),
    .m_axis_c2h_tkeep  (tkeep),
    .m_axis_c2h_tvalid (tvalid),
    .m_axis_c2h_tready (tready),
    .m_axis_c2h_tlast  (tlast),
    .busy              (busy),
    .pkt_count         (pkt_count),
    .drop_err          (drop_err)
  );

  always #5 clk = ~clk;

  int               n_checks = 0;
  int               n_fail   = 0;
  beat_t            exp_q[$];
  int               hs_count = 0;
  int               nxt_seen = 0;
  int               rmode    = 0;
  logic [CNT_W-1:0] exp_cnt  = '0;

  task automatic check(input string name, input logic [BEAT_W-1:0] act, input logic [BEAT_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [PKT_W-1:0] rand_pkt(input logic [7:0] seq);
    logic [4095:0] t;
    for (int w = 0; w < 128; w++) t[w*32 +: 32] = $urandom;
    t[7:0] = seq;
    return t[PKT_W-1:0];
  endfunction

  // Reference model: split the zero-extended packet into LSB-first beats; keep covers real bytes only.
  task automatic push_model(input logic [PKT_W-1:0] p);
    logic [NB*BEAT_W-1:0] ext;
    beat_t b;
    int nbytes;
    ext = '0;
    ext[PKT_W-1:0] = p;
    for (int i = 0; i < NB; i++) begin
      b.data = ext[i*BEAT_W +: BEAT_W];
      nbytes = PKT_W / 8 - i * KW;
      if (nbytes > KW) nbytes = KW;
      b.keep = '0;
      for (int k = 0; k < nbytes; k++) b.keep[k] = 1'b1;
      b.last = (i == NB - 1);
      exp_q.push_back(b);
    end
  endtask

  task automatic send(input logic [PKT_W-1:0] p);
    @(posedge clk); #1;
    push_model(p);
    in_data  = p;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!busy && !tvalid) begin
        ok = 1'b1;
        break;
      end
    end
    check(name, ok, 1);
  endtask

  // Returns at negedge+1 of the cycle in which beat n is on the bus.
  task automatic wait_beat(input string name, input int base, input int n);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk); #1;
      if (hs_count - base >= n + 1) begin
        ok = 1'b1;
        break;
      end
    end
    check(name, ok, 1);
  endtask

  initial begin
    int pc;
    pc = 0;
    tready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rmode)
        0:       tready = 1'b1;
        1:       begin tready = (pc % 3 == 0); pc++; end
        default: tready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: scoreboard pop on handshake, AXIS stability while stalled, in_next pulse count.
  initial begin
    logic              hold;
    logic [BEAT_W-1:0] h_data;
    logic [KW-1:0]     h_keep;
    logic              h_last;
    beat_t             b;
    hold = 1'b0;
    forever begin
      @(negedge clk);
      if (areset) begin
        hold = 1'b0;
      end else begin
        if (in_next) nxt_seen++;
        if (hold) begin
          check("stall_tvalid", tvalid, 1);
          check("stall_tdata", tdata, h_data);
          check("stall_tkeep", tkeep, h_keep);
          check("stall_tlast", tlast, h_last);
        end
        if (tvalid && tready) begin
          hs_count++;
          hold = 1'b0;
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_underflow: got beat %0h expected no beat", tdata);
          end else begin
            b = exp_q.pop_front();
            check("beat_tdata", tdata, b.data);
            check("beat_tkeep", tkeep, b.keep);
            check("beat_tlast", tlast, b.last);
          end
        end else if (tvalid) begin
          hold   = 1'b1;
          h_data = tdata;
          h_keep = tkeep;
          h_last = tlast;
        end else begin
          hold = 1'b0;
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [PKT_W-1:0] pkt_a5;
    logic [PKT_W-1:0] p;
    int n0, base, nxt_cnt, nxt_at;

    pkt_a5   = {{(PKT_W/8-1){8'hA5}}, 8'h03};
    areset   = 1'b1;
    flush    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (3) @(posedge clk);
    #1 areset = 1'b0;
    @(negedge clk);

    check("rst_tvalid", tvalid, 0);
    check("rst_tlast", tlast, 0);
    check("rst_tkeep", tkeep, 0);
    check("rst_tdata", tdata, 0);
    check("rst_in_next", in_next, 0);
    check("rst_busy", busy, 0);
    check("rst_drop_err", drop_err, 0);
    check("rst_pkt_count", pkt_count, exp_cnt);

    // Test 1: reference packet, tready always high, exact latencies.
    rmode = 0;
    send(pkt_a5);
    nxt_cnt = 0;
    nxt_at  = -1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) check("t1_tvalid_latency", tvalid, 1);
      if (k == 8) check("t1_tlast_beat7", tlast, 1);
      if (in_next) begin
        nxt_cnt++;
        nxt_at = k;
      end
    end
    exp_cnt++;
    check("t1_in_next_count", nxt_cnt, 1);
    check("t1_in_next_cycle", nxt_at, 9);
    check("t1_pkt_count", pkt_count, exp_cnt);
    check("t1_busy_after", busy, 0);
    check("t1_sb_empty", exp_q.size(), 0);

    // Test 2: tready 1,0,0 pattern stalls the stream.
    rmode = 1;
    n0 = nxt_seen;
    send(pkt_a5);
    wait_idle("t2_done");
    exp_cnt++;
    check("t2_in_next_count", nxt_seen - n0, 1);
    check("t2_pkt_count", pkt_count, exp_cnt);
    check("t2_sb_empty", exp_q.size(), 0);

    // Test 3: second packet offered during beat 3 is dropped.
    rmode = 0;
    base = hs_count;
    n0 = nxt_seen;
    send(pkt_a5);
    wait_beat("t3_reach_beat3", base, 3);
    in_data  = rand_pkt(8'h77);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_idle("t3_done");
    exp_cnt++;
    check("t3_drop_err", drop_err, 1);
    check("t3_in_next_count", nxt_seen - n0, 1);
    check("t3_pkt_count", pkt_count, exp_cnt);
    check("t3_sb_empty", exp_q.size(), 0);
    rmode = 2;
    send(rand_pkt(8'h10));
    wait_idle("t3b_done");
    exp_cnt++;
    check("t3_drop_err_sticky", drop_err, 1);
    check("t3b_pkt_count", pkt_count, exp_cnt);

    // Test 4: flush during beat 5; stream drains, no in_next, counters cleared.
    rmode = 0;
    base = hs_count;
    n0 = nxt_seen;
    send(rand_pkt(8'h20));
    wait_beat("t4_reach_beat5", base, 5);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    wait_idle("t4_done");
    exp_cnt = '0;
    check("t4_in_next_none", nxt_seen - n0, 0);
    check("t4_pkt_count", pkt_count, exp_cnt);
    check("t4_drop_err", drop_err, 0);
    check("t4_sb_empty", exp_q.size(), 0);
    // Flush in IDLE masks a same-cycle in_valid.
    @(posedge clk); #1;
    in_data  = rand_pkt(8'h21);
    in_valid = 1'b1;
    flush    = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    flush    = 1'b0;
    repeat (3) @(negedge clk);
    check("t4_idle_flush_tvalid", tvalid, 0);
    check("t4_idle_flush_busy", busy, 0);

    // Test 5: reset mid-transfer at beat 4, then a fresh packet.
    base = hs_count;
    send(rand_pkt(8'h30));
    wait_beat("t5_reach_beat4", base, 4);
    areset = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    areset = 1'b0;
    @(negedge clk);
    exp_cnt = '0;
    check("t5_tvalid_after_rst", tvalid, 0);
    check("t5_busy_after_rst", busy, 0);
    check("t5_pkt_count_after_rst", pkt_count, exp_cnt);
    n0 = nxt_seen;
    send(rand_pkt(8'h31));
    wait_idle("t5_fresh_done");
    exp_cnt++;
    check("t5_fresh_in_next", nxt_seen - n0, 1);
    check("t5_fresh_pkt_count", pkt_count, exp_cnt);
    check("t5_sb_empty", exp_q.size(), 0);

    // Test 6: counter wrap from all-ones.
    @(negedge clk);
    force dut.pkt_count = '1;
    #1 release dut.pkt_count;
    exp_cnt = '1;
    check("t6_preload", pkt_count, exp_cnt);
    send(rand_pkt(8'h40));
    wait_idle("t6_done");
    exp_cnt++;
    check("t6_wrap", pkt_count, exp_cnt);

    // Random phase: random payloads with random backpressure.
    rmode = 2;
    for (int i = 0; i < 4; i++) begin
      n0 = nxt_seen;
      send(rand_pkt(8'(8'h50 + i)));
      wait_idle("rnd_done");
      exp_cnt++;
      check("rnd_in_next", nxt_seen - n0, 1);
      check("rnd_pkt_count", pkt_count, exp_cnt);
    end
    check("final_sb_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
